// File: rtl/mcdf_arbiter_if.sv
// Signal bundle between the MCDF arbiter, its slave_fifo channels and the formatter.
// slave is the arbiter's view; master is the environment driving channels and margin.
interface mcdf_arbiter_if #(
  parameter int NUM_SLV = 3,
  parameter int DW      = 32
);
  logic [NUM_SLV-1:0]    slv_req_i;
  logic [NUM_SLV-1:0]    slv_valid_i;
  logic [NUM_SLV*DW-1:0] slv_data_i;
  logic [2*NUM_SLV-1:0]  slv_prio_i;
  logic [3*NUM_SLV-1:0]  slv_pkglen_i;
  logic [6:0]            f2a_margin_i;
  logic [NUM_SLV-1:0]    a2s_ack_o;
  logic                  a2f_valid_o;
  logic [DW-1:0]         a2f_data_o;
  logic [1:0]            a2f_id_o;
  logic                  a2f_sop_o;
  logic                  a2f_eop_o;
  logic [5:0]            a2f_len_o;
  logic                  busy_o;

  modport slave (
    input  slv_req_i, slv_valid_i, slv_data_i, slv_prio_i, slv_pkglen_i, f2a_margin_i,
    output a2s_ack_o, a2f_valid_o, a2f_data_o, a2f_id_o, a2f_sop_o, a2f_eop_o,
           a2f_len_o, busy_o
  );

  modport master (
    output slv_req_i, slv_valid_i, slv_data_i, slv_prio_i, slv_pkglen_i, f2a_margin_i,
    input  a2s_ack_o, a2f_valid_o, a2f_data_o, a2f_id_o, a2f_sop_o, a2f_eop_o,
           a2f_len_o, busy_o
  );
endinterface

// File: rtl/mcdf_arbiter.sv
// Packet arbiter: priority with round-robin tie-break, acks one whole packet per grant
// and forwards the returned beats tagged with channel id and sop/eop.
module mcdf_arbiter #(
  parameter int NUM_SLV = 3,
  parameter int DW      = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mcdf_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACK, DRAIN} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [1:0]         r_ch;
  logic [1:0]         r_last_grant;
  logic [5:0]         r_len;
  logic [5:0]         r_ack_cnt;
  logic [5:0]         r_beat_cnt;
  logic               r_mask_vld;
  logic [NUM_SLV-1:0] r_ack;
  logic               r_valid;
  logic [DW-1:0]      r_data;
  logic [1:0]         r_id;
  logic               r_sop;
  logic               r_eop;

  logic [NUM_SLV-1:0][5:0] w_len;
  logic [NUM_SLV-1:0][1:0] w_prio;
  logic [NUM_SLV-1:0]      w_elig;
  logic                    w_found;
  logic [1:0]              w_win;
  logic                    w_beat_fire;
  logic                    w_ack_last;
  logic                    w_eop_beat;

  function automatic logic [5:0] decode_len(input logic [2:0] code);
    case (code)
      3'd0:    return 6'd4;
      3'd1:    return 6'd8;
      3'd2:    return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_ch
      assign w_len[gi]  = decode_len(bus.slv_pkglen_i[3*gi +: 3]);
      assign w_prio[gi] = bus.slv_prio_i[2*gi +: 2];
      // The just-served slave still shows its request for one cycle after its packet.
      assign w_elig[gi] = bus.slv_req_i[gi]
                          && !(r_mask_vld && (r_ch == 2'(gi)))
                          && ({1'b0, w_len[gi]} <= bus.f2a_margin_i);
    end
  endgenerate

  // Rank is the distance after last_grant, so equal priorities resolve round-robin.
  always_comb begin
    int         rank;
    int         best_rank;
    logic [1:0] best_prio;
    rank      = 0;
    best_rank = NUM_SLV;
    best_prio = '1;
    w_found   = 1'b0;
    w_win     = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      rank = i - int'(r_last_grant) - 1;
      if (rank < 0) rank = rank + NUM_SLV;
      if (w_elig[i] && (!w_found || (w_prio[i] < best_prio)
                        || ((w_prio[i] == best_prio) && (rank < best_rank)))) begin
        w_found   = 1'b1;
        w_win     = 2'(i);
        best_prio = w_prio[i];
        best_rank = rank;
      end
    end
  end

  assign w_ack_last  = (r_ack_cnt == r_len - 6'd1);
  assign w_eop_beat  = (r_beat_cnt == r_len - 6'd1);
  assign w_beat_fire = (r_state != IDLE) && bus.slv_valid_i[r_ch] && (r_beat_cnt < r_len);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_next = ACK;
      ACK:     if (w_ack_last) w_state_next = DRAIN;
      DRAIN:   if ((r_beat_cnt == r_len) || (w_beat_fire && w_eop_beat)) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ch         <= '0;
      r_last_grant <= 2'(NUM_SLV - 1);
      r_len        <= '0;
      r_ack_cnt    <= '0;
      r_beat_cnt   <= '0;
      r_mask_vld   <= 1'b0;
      r_ack        <= '0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_id         <= '0;
      r_sop        <= 1'b0;
      r_eop        <= 1'b0;
    end else begin
      r_mask_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_ch         <= w_win;
            r_len        <= w_len[w_win];
            r_last_grant <= w_win;
            r_ack_cnt    <= '0;
            r_beat_cnt   <= '0;
            r_ack        <= NUM_SLV'(1) << w_win;
          end
        end
        ACK: begin
          r_ack_cnt <= r_ack_cnt + 6'd1;
          if (w_ack_last) r_ack <= '0;
        end
        DRAIN: begin
          if (w_state_next == IDLE) r_mask_vld <= 1'b1;
        end
        default: r_ack <= '0;
      endcase

      if (w_beat_fire) begin
        r_valid    <= 1'b1;
        r_data     <= bus.slv_data_i[int'(r_ch)*DW +: DW];
        r_id       <= r_ch;
        r_sop      <= (r_beat_cnt == 6'd0);
        r_eop      <= w_eop_beat;
        r_beat_cnt <= r_beat_cnt + 6'd1;
      end else begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_id    <= '0;
        r_sop   <= 1'b0;
        r_eop   <= 1'b0;
      end
    end
  end

  assign bus.a2s_ack_o   = r_ack;
  assign bus.a2f_valid_o = r_valid;
  assign bus.a2f_data_o  = r_data;
  assign bus.a2f_id_o    = r_id;
  assign bus.a2f_sop_o   = r_sop;
  assign bus.a2f_eop_o   = r_eop;
  assign bus.a2f_len_o   = r_len;
  assign bus.busy_o      = (r_state != IDLE);
endmodule
